bool_to_reset_gen: RTL and testbench
====================================

// Module: bool_to_reset_gen
// PURPOSE
//  Converts a synchronous boolean reset request (VAL, active-high) into a clean
//  active-low reset (OUT_RST) in the CLK domain, for resetting sub-blocks under
//  software or FSM control. This is the inverse of reset-to-boolean conversion.
//  OUT_RST assertion is registered (one cycle). Deassertion is stretched by a
//  hold counter and is always synchronous to CLK.
// PARAMETERS
//  RSTHOLD    4  cycles OUT_RST stays low after the request drops; legal range 1..2^CNT_WIDTH-1
//  CNT_WIDTH  8  hold counter width; elaboration error if RSTHOLD >= 2**CNT_WIDTH or RSTHOLD < 1
// PORTS
//  CLK      in   1          clock; all state on rising edge
//  RST      in   1          asynchronous, active-low reset for the block itself
//  VAL      in   1          reset request; 1 = hold OUT_RST asserted
//  OUT_RST  out  1          generated reset, active-low, deasserts synchronously to CLK
//  BUSY     out  1          1 while in S_HOLD (release in progress)
//  HOLD_CNT out  CNT_WIDTH  current hold count, for debug/observability
// BEHAVIOUR
//  - Async reset (RST==0): immediately state=S_RESET, cnt=0, OUT_RST=0, BUSY=0, HOLD_CNT=0.
//    These values hold for as long as RST is low.
//  - VALe is the effective request: VAL, or the synchronised VAL (see CONFIGURATION).
//  - FSM, evaluated at every rising CLK edge while RST==1:
//    S_RESET: OUT_RST=0. If VALe==0, go to S_HOLD with cnt=0. Otherwise stay.
//    S_HOLD : OUT_RST=0, BUSY=1.
//             If VALe==1, go to S_RESET with cnt=0; the release aborts.
//             Else if cnt==RSTHOLD-1, go to S_RUN with OUT_RST<=1.
//             Else cnt<=cnt+1.
//    S_RUN  : OUT_RST=1. If VALe==1, go to S_RESET; OUT_RST<=0 at that same edge.
//  - Latency. Let E0 be the first edge that samples VALe==0 in S_RESET.
//    OUT_RST rises at edge E0+RSTHOLD. Assertion latency from S_RUN is 1 edge.
//  - All outputs are registered; no combinational path from VAL to OUT_RST.
//  - BUSY and HOLD_CNT are registered and track state/cnt. HOLD_CNT is 0 outside S_HOLD.
//  - The counter never wraps; cnt saturates by construction at RSTHOLD-1.
//  - RST release: the FSM starts in S_RESET. OUT_RST stays low for at least
//    RSTHOLD edges after RST rises, even if VAL is already 0.
//  - RST asserted mid-hold or mid-run: OUT_RST drops asynchronously and cnt clears.
//  - A VALe pulse of 1 cycle in S_RUN still produces a full low pulse on OUT_RST
//    lasting 1+RSTHOLD cycles.
//  - Illegal state encodings recover to S_RESET on the next edge.
// CONFIGURATION
//  BOOL_TO_RESET_SYNC_EN
//  - Defined: VAL passes through a 2-flop synchroniser (VALe = sync[1]) so VAL
//    may be asynchronous to CLK. Both sync flops reset to 1, which keeps OUT_RST
//    asserted through RST release. Adds 2 edges of latency to both assertion and
//    deassertion.
//  - Undefined: VALe = VAL. VAL must be synchronous to CLK. No added latency.
// TESTING (RSTHOLD=4, CNT_WIDTH=8, macro undefined unless stated)
//  1. RST=0 for 3 cycles with VAL=0, then release RST:
//     OUT_RST=0 during reset; rises exactly 4 edges after RST rises; BUSY high for those 4 cycles.
//  2. In S_RUN, VAL=1 for exactly 1 cycle:
//     OUT_RST falls at the next edge and stays low 5 cycles total; HOLD_CNT steps 0,1,2,3.
//  3. In S_HOLD at HOLD_CNT=2, VAL=1 for 1 cycle:
//     FSM returns to S_RESET, HOLD_CNT=0; OUT_RST rises 4 edges after VAL falls.
//  4. In S_RUN, drop RST asynchronously mid-cycle:
//     OUT_RST goes 0 with no clock edge; BUSY=0, HOLD_CNT=0.
//  5. Macro defined; async VAL pulses 0->1 then 1->0 after 10 cycles:
//     OUT_RST falls 3 edges after the VAL rise and rises 6 edges after the VAL fall.
//  6. Hold VAL=1 for 100 cycles:
//     OUT_RST stays 0, BUSY stays 0, HOLD_CNT stays 0 throughout.

Source files
------------

// File: rtl/bool_to_reset_gen_if.sv
// Purpose : bundles the reset request and the generated reset/status of bool_to_reset_gen.
// Latency : none (wiring only).
// Backpressure: none; val is a level request and the outputs are level status.
//
// Signals:
//   val      requester -> generator  1 = hold out_rst asserted
//   out_rst  generator -> requester  generated reset, active-low
//   busy     generator -> requester  1 while a release is in progress
//   hold_cnt generator -> requester  current hold count (0 outside the hold phase)
interface bool_to_reset_gen_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 val;
    logic                 out_rst;
    logic                 busy;
    logic [CNT_WIDTH-1:0] hold_cnt;

    // master: the block asking for a reset; slave: the reset generator.
    modport master (output val, input out_rst, input busy, input hold_cnt);
    modport slave  (input val, output out_rst, output busy, output hold_cnt);
endinterface

// File: rtl/bool_to_reset_gen.sv
// Purpose : turns a boolean reset request into a clean active-low reset in the clk domain.
// Latency : assertion 1 edge; release RSTHOLD edges after the request is first seen low (+2 edges each with sync).
// Backpressure: none; the request is a level and may change at any cycle.
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset of this block (forces out_rst low at once)
//   rif    bool_to_reset_gen_if.slave: val in; out_rst, busy, hold_cnt out
// Optional feature: define BOOL_TO_RESET_SYNC_EN to pass val through a 2-flop
// synchroniser so it may be asynchronous to clk.
module bool_to_reset_gen #(
    parameter int RSTHOLD   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bool_to_reset_gen_if.slave rif
);

    if (RSTHOLD < 1 || RSTHOLD >= (1 << CNT_WIDTH)) begin : g_param_chk
        $error("bool_to_reset_gen: RSTHOLD must be in 1..2**CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RSTHOLD - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_HOLD  = 2'b01,
        S_RUN   = 2'b10
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 out_rst_q;
    logic                 busy_q;
    logic                 vale;

`ifdef BOOL_TO_RESET_SYNC_EN
    // Both flops reset to 1 so the request reads as "asserted" until real
    // samples of val have propagated, keeping out_rst low through rst_n release.
    logic [1:0] val_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_sync <= 2'b11;
        end else begin
            val_sync <= {val_sync[0], rif.val};
        end
    end

    assign vale = val_sync[1];
`else
    assign vale = rif.val;
`endif

    // cnt is cleared on every exit from S_HOLD, so it doubles directly as the
    // hold_cnt output (0 outside S_HOLD) without any extra decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            cnt       <= '0;
            out_rst_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    out_rst_q <= 1'b0;
                    cnt       <= '0;
                    if (!vale) begin
                        state  <= S_HOLD;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (vale) begin
                        // Request came back before release finished: start over.
                        state     <= S_RESET;
                        cnt       <= '0;
                        busy_q    <= 1'b0;
                        out_rst_q <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        busy_q    <= 1'b0;
                        out_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    if (vale) begin
                        state     <= S_RESET;
                        out_rst_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_RESET;
                    cnt       <= '0;
                    busy_q    <= 1'b0;
                    out_rst_q <= 1'b0;
                end
            endcase
        end
    end

    assign rif.out_rst  = out_rst_q;
    assign rif.busy     = busy_q;
    assign rif.hold_cnt = cnt;

endmodule

// File: tb/tb_bool_to_reset_gen.sv
// Purpose : self-checking bench for bool_to_reset_gen (RSTHOLD=4, CNT_WIDTH=8).
// Latency : n/a.
// Backpressure: n/a.
//
// The reference model tracks how many consecutive edges have sampled the
// effective request low since the last reset/request; out_rst must be high
// once that run exceeds RSTHOLD, and busy/hold_cnt follow from the run length.
module tb_bool_to_reset_gen;

    localparam int RSTHOLD   = 4;
    localparam int CNT_WIDTH = 8;
`ifdef BOOL_TO_RESET_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bool_to_reset_gen_if #(.CNT_WIDTH(CNT_WIDTH)) rif ();

    bool_to_reset_gen #(
        .RSTHOLD   (RSTHOLD),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rif   (rif)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       zrun = 0;          // consecutive edges that saw the request low
    logic [1:0] vdly = 2'b11;    // request delay line, used only with the synchroniser
    logic     m_vale;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zrun = 0;
            vdly = 2'b11;
        end else begin
            m_vale = (SYNC_LAT == 0) ? rif.val : vdly[1];
            vdly   = {vdly[0], rif.val};
            if (m_vale) zrun = 0;
            else if (zrun < 100000) zrun = zrun + 1;
        end
    end

    function automatic int exp_out();
        return (zrun > RSTHOLD) ? 1 : 0;
    endfunction

    function automatic int exp_busy();
        return (zrun >= 1 && zrun <= RSTHOLD) ? 1 : 0;
    endfunction

    function automatic int exp_hold();
        return (zrun >= 1 && zrun <= RSTHOLD) ? zrun - 1 : 0;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_out_rst",  int'(rif.out_rst),  exp_out());
        check("cyc_busy",     int'(rif.busy),     exp_busy());
        check("cyc_hold_cnt", int'(rif.hold_cnt), exp_hold());
    end

    task automatic drive_slot();
        @(negedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    int edges, busy_cyc, fall_at, low_cyc, viol;
    int hq[$];

    initial begin
        rif.val = 1'b0;

        // Reset state, checked without any clock edge involvement.
        #1;
        check("rst_out_rst",  int'(rif.out_rst), 0);
        check("rst_busy",     int'(rif.busy), 0);
        check("rst_hold_cnt", int'(rif.hold_cnt), 0);
        repeat (3) @(negedge clk);

        // Test 1: release rst_n with val already low.
        #2;
        rst_n    = 1'b1;
        edges    = 0;
        busy_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (rif.busy) busy_cyc++;
            if (rif.out_rst) break;
        end
        check("t1_release_edges", edges, 1 + SYNC_LAT + RSTHOLD);
        check("t1_busy_cycles",   busy_cyc, RSTHOLD);
        repeat (3) @(negedge clk);

        // Test 2: one-cycle request while running.
        #2;
        rif.val = 1'b1;
        fall_at = 0;
        low_cyc = 0;
        hq.delete();
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) rif.val = 1'b0;
            if (!rif.out_rst) begin
                if (fall_at == 0) fall_at = n;
                low_cyc++;
                if (rif.busy) hq.push_back(int'(rif.hold_cnt));
            end else if (fall_at != 0) begin
                break;
            end
        end
        check("t2_assert_edges", fall_at, 1 + SYNC_LAT);
        check("t2_low_cycles",   low_cyc, 1 + RSTHOLD);
        check("t2_hold_len",     hq.size(), RSTHOLD);
        for (int i = 0; i < hq.size(); i++) check("t2_hold_step", hq[i], i);
        repeat (2) @(negedge clk);

`ifndef BOOL_TO_RESET_SYNC_EN
        // Test 3: abort a release at hold_cnt == 2.
        drive_slot();
        rif.val = 1'b1;
        drive_slot();
        rif.val = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rif.busy && rif.hold_cnt == 2) break;
        end
        check("t3_reached_cnt2", int'(rif.hold_cnt), 2);
        #2;
        rif.val = 1'b1;
        @(posedge clk);
        #1;
        rif.val = 1'b0;
        check("t3_abort_busy", int'(rif.busy), 0);
        check("t3_abort_hold", int'(rif.hold_cnt), 0);
        check("t3_abort_out",  int'(rif.out_rst), 0);
        edges = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (rif.out_rst) break;
        end
        check("t3_release_edges", edges, 1 + RSTHOLD);
        repeat (2) @(negedge clk);
`endif

        // Test 4: async reset mid-run, then async reset mid-hold.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_run_out", int'(rif.out_rst), 0);
        check("t4_run_busy", int'(rif.busy), 0);
        check("t4_run_hold", int'(rif.hold_cnt), 0);
        repeat (2) drive_slot();
        rst_n = 1'b1;
        repeat (SYNC_LAT + 3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_hold_busy", int'(rif.busy), 0);
        check("t4_hold_cnt",  int'(rif.hold_cnt), 0);
        check("t4_hold_out",  int'(rif.out_rst), 0);
        drive_slot();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rif.out_rst) break;
        end
        check("t4_recovered", int'(rif.out_rst), 1);

        // Test 6: request held for 100 cycles.
        drive_slot();
        rif.val = 1'b1;
        repeat (SYNC_LAT + 1) @(negedge clk);
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (rif.out_rst || rif.busy || rif.hold_cnt != 0) viol++;
        end
        check("t6_quiet_cycles", viol, 0);
        #2;
        rif.val = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rif.out_rst) break;
        end
        check("t6_final_release", int'(rif.out_rst), 1);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
